// File: rtl/aes_core.sv
// aes_core: iterative AES-128/256 block cipher, one round per clock, with on-chip key expansion.
// Define AES_CORE_DEC_EN to compile in the decryption datapath (encdec then selects direction).

module aes_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         encdec,
  input  logic         init,
  input  logic         next,
  output logic         ready,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [127:0] result,
  output logic         result_valid
);
  localparam int unsigned NB_RK = 15;
  localparam int unsigned BLK_W = 128;

  typedef enum logic {K_IDLE, K_EXPAND} key_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ROUNDS, C_DONE} cip_state_t;

  key_state_t       r_kstate, w_kstate_nxt;
  cip_state_t       r_cstate, w_cstate_nxt;
  logic [BLK_W-1:0] r_rk [NB_RK];
  logic [BLK_W-1:0] r_key_lo, r_state, r_result;
  logic             r_keylen, r_ready, r_result_valid;
  logic [3:0]       r_kcnt, r_round, w_nr, w_rk_idx, w_rcon_idx;
  logic [BLK_W-1:0] w_rk_m1, w_rk_m2, w_rk_base, w_rk_new, w_rk_cur, w_ark0;
  logic [BLK_W-1:0] w_sb, w_isb, w_enc_sr, w_enc_out, w_dec_ark, w_dec_out, w_round_out;
  logic [31:0]      w_ks_word, w_ks_sub, w_ks_t, w_c0, w_c1, w_c2, w_c3;
  logic             w_ks_rot, w_accept, w_last, w_dec, w_dec_req;

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] v;
    case (n)
      4'd1: v = 8'h01;  4'd2: v = 8'h02;  4'd3: v = 8'h04;  4'd4: v = 8'h08;
      4'd5: v = 8'h10;  4'd6: v = 8'h20;  4'd7: v = 8'h40;  4'd8: v = 8'h80;
      4'd9: v = 8'h1b;  4'd10: v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  // Byte i of the block is s[127-8i -: 8]; column c holds bytes 4c..4c+3, row r = i % 4
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((inv ? c - r + 4 : c + r) % 4) + r) -: 8];
    return o;
  endfunction

  // Circulant coefficients {2,3,1,1} forward, {14,11,13,9} inverse, one nibble each
  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [15:0]  coef;
    logic [7:0]   acc;
    logic [127:0] o;
    coef = inv ? 16'hebd9 : 16'h2311;
    o    = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gm(s[127 - 8*(4*c + j) -: 8], coef[15 - 4*((j - r + 4) % 4) -: 4]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction

  assign w_nr = r_keylen ? 4'd14 : 4'd10;

  // Key schedule: AES-256 odd entries use SubWord only, with base two entries back
  assign w_rk_m1    = r_rk[r_kcnt - 4'd1];
  assign w_rk_m2    = (r_kcnt >= 4'd2) ? r_rk[r_kcnt - 4'd2] : '0;
  assign w_rk_base  = r_keylen ? w_rk_m2 : w_rk_m1;
  assign w_ks_rot   = !r_keylen || !r_kcnt[0];
  assign w_ks_word  = w_ks_rot ? {w_rk_m1[23:0], w_rk_m1[31:24]} : w_rk_m1[31:0];
  assign w_rcon_idx = r_keylen ? {1'b0, r_kcnt[3:1]} : r_kcnt;
  assign w_ks_t     = w_ks_sub ^ (w_ks_rot ? {rcon(w_rcon_idx), 24'h0} : 32'h0);
  assign w_c0       = w_rk_base[127:96] ^ w_ks_t;
  assign w_c1       = w_rk_base[95:64] ^ w_c0;
  assign w_c2       = w_rk_base[63:32] ^ w_c1;
  assign w_c3       = w_rk_base[31:0] ^ w_c2;
  assign w_rk_new   = (r_keylen && r_kcnt == 4'd1) ? r_key_lo : {w_c0, w_c1, w_c2, w_c3};

  for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
    aes_sbox u_sbox (.i_in(w_ks_word[8*g +: 8]), .o_out(w_ks_sub[8*g +: 8]));
  end

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (.i_in(r_state[8*g +: 8]), .o_out(w_sb[8*g +: 8]));
  end

`ifdef AES_CORE_DEC_EN
  logic r_dec;

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (.i_in(r_state[8*g +: 8]), .o_out(w_isb[8*g +: 8]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_dec <= 1'b0;
    else if (w_accept) r_dec <= !encdec;
  end

  assign w_dec     = r_dec;
  assign w_dec_req = !encdec;
`else
  logic w_unused_encdec;
  assign w_unused_encdec = encdec;
  assign w_isb     = '0;
  assign w_dec     = 1'b0;
  assign w_dec_req = 1'b0;
`endif

  // Round datapath; SubBytes commutes with ShiftRows, so S-boxes sit directly on the state
  assign w_last      = (r_round == w_nr);
  assign w_rk_idx    = w_dec ? (w_nr - r_round) : r_round;
  assign w_rk_cur    = r_rk[w_rk_idx];
  assign w_enc_sr    = shift_rows(w_sb, 1'b0);
  assign w_enc_out   = (w_last ? w_enc_sr : mix_cols(w_enc_sr, 1'b0)) ^ w_rk_cur;
  assign w_dec_ark   = shift_rows(w_isb, 1'b1) ^ w_rk_cur;
  assign w_dec_out   = w_last ? w_dec_ark : mix_cols(w_dec_ark, 1'b1);
  assign w_round_out = w_dec ? w_dec_out : w_enc_out;
  assign w_ark0      = block ^ (w_dec_req ? r_rk[w_nr] : r_rk[0]);
  assign w_accept    = next && !init && r_ready && (r_cstate != C_ROUNDS);

  always_comb begin
    w_kstate_nxt = r_kstate;
    case (r_kstate)
      K_IDLE:   if (init) w_kstate_nxt = K_EXPAND;
      K_EXPAND: if (!init && r_kcnt == w_nr) w_kstate_nxt = K_IDLE;
      default:  w_kstate_nxt = K_IDLE;
    endcase
  end

  always_comb begin
    w_cstate_nxt = r_cstate;
    if (init) w_cstate_nxt = C_IDLE;
    else begin
      case (r_cstate)
        C_IDLE, C_DONE: if (w_accept) w_cstate_nxt = C_ROUNDS;
        C_ROUNDS:       if (w_last) w_cstate_nxt = C_DONE;
        default:        w_cstate_nxt = C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kstate <= K_IDLE;
      r_kcnt   <= '0;
      r_keylen <= 1'b0;
      r_key_lo <= '0;
      r_ready  <= 1'b1;
      for (int unsigned i = 0; i < NB_RK; i++) r_rk[i] <= '0;
    end else begin
      r_kstate <= w_kstate_nxt;
      r_ready  <= (w_kstate_nxt == K_IDLE);
      if (init) begin
        r_keylen <= keylen;
        r_key_lo <= key[127:0];
        r_rk[0]  <= key[255:128];
        r_kcnt   <= 4'd1;
      end else if (r_kstate == K_EXPAND) begin
        r_rk[r_kcnt] <= w_rk_new;
        r_kcnt       <= r_kcnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cstate       <= C_IDLE;
      r_round        <= '0;
      r_state        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_cstate <= w_cstate_nxt;
      if (init) r_result_valid <= 1'b0;
      else if (w_accept) begin
        r_state        <= w_ark0;
        r_round        <= 4'd1;
        r_result_valid <= 1'b0;
      end else if (r_cstate == C_ROUNDS) begin
        r_state <= w_round_out;
        r_round <= r_round + 4'd1;
        if (w_last) begin
          r_result       <= w_round_out;
          r_result_valid <= 1'b1;
        end
      end
    end
  end

  assign ready        = r_ready;
  assign result       = r_result;
  assign result_valid = r_result_valid;
endmodule

// Forward S-box: GF(2^8) inverse followed by the AES affine transform
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  logic [7:0] w_inv;
  aes_gf_inv u_inv (.i_a(i_in), .o_inv(w_inv));
  assign o_out = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

`ifdef AES_CORE_DEC_EN
// Inverse S-box: inverse affine transform followed by the GF(2^8) inverse
module aes_inv_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  logic [7:0] w_aff;
  assign w_aff = {i_in[6:0], i_in[7]} ^ {i_in[4:0], i_in[7:5]} ^ {i_in[1:0], i_in[7:2]} ^ 8'h05;
  aes_gf_inv u_inv (.i_a(w_aff), .o_inv(o_out));
endmodule
`endif

// Multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1 as a^254, so 0 maps to 0
module aes_gf_inv (
  input  logic [7:0] i_a,
  output logic [7:0] o_inv
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, p;
    sq = a;
    p  = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  assign o_inv = gf_inv(i_a);
endmodule

// File: tb/tb_aes_core.sv
// tb_aes_core: directed and randomized checks of aes_core against a byte-level AES model.
// Honours AES_CORE_DEC_EN the same way as the design (decrypt vectors only when defined).

module tb_aes_core;
  logic         clk = 1'b0;
  logic         rst_n, encdec, init, next, keylen, ready, result_valid;
  logic [255:0] key;
  logic [127:0] block, result;
  int           total = 0;
  int           bad   = 0;
  logic [7:0]   sbox_t [256];
  logic [7:0]   isbox_t[256];

  localparam int ME[4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
  localparam int MD[4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KFIP = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTF  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTF  = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_core dut (
    .clk(clk), .rst_n(rst_n), .encdec(encdec), .init(init), .next(next), .ready(ready),
    .key(key), .keylen(keylen), .block(block), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Classic generator walk: p steps through powers of 3, q through powers of 1/3
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_st(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv ? isbox_t[gb(s, i)] : sbox_t[gb(s, i)];
    return o;
  endfunction

  // Forward gathers row r left by r; inverse scatters the same way so it undoes it
  function automatic logic [127:0] shift_st(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!inv) o[127 - 8*(r + 4*c) -: 8] = gb(s, r + 4*((c + r) % 4));
        else      o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = gb(s, r + 4*c);
    return o;
  endfunction

  function automatic logic [127:0] mix_st(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(gb(s, 4*c + j), 8'(inv ? MD[r][j] : ME[r][j]));
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_model(input logic [255:0] k, input logic k256,
                                             input logic [127:0] blk, input logic enc);
    logic [31:0]  w[60];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] st;
    int           nk, nr;
    nk = k256 ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    if (enc) begin
      st = blk ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= nr; r++) begin
        st = shift_st(sub_st(st, 1'b0), 1'b0);
        if (r < nr) st = mix_st(st, 1'b0);
        st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
    end else begin
      st = blk ^ {w[4*nr], w[4*nr+1], w[4*nr+2], w[4*nr+3]};
      for (int r = nr - 1; r >= 0; r--) begin
        st = sub_st(shift_st(st, 1'b1), 1'b1);
        st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        if (r > 0) st = mix_st(st, 1'b1);
      end
    end
    return st;
  endfunction

  task automatic do_init(input logic [255:0] k, input logic kl, input string tag);
    int n;
    key = k; keylen = kl; init = 1'b1;
    tick();
    init = 1'b0; key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    keylen = ~kl;
    check({tag, "_busy"}, 256'(ready), 256'(0));
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    check({tag, "_ready_lat"}, 256'(n), 256'(kl ? 14 : 10));
  endtask

  task automatic run_block(input logic [127:0] b, input logic ed, input logic [127:0] exp,
                           input int nr, input string tag);
    int n;
    block = b; encdec = ed; next = 1'b1;
    tick();
    next = 1'b0; block = {$urandom, $urandom, $urandom, $urandom}; encdec = ~ed;
    check({tag, "_valid_low"}, 256'(result_valid), 256'(0));
    n = 0;
    while (!result_valid && n < 40) begin tick(); n++; end
    check({tag, "_lat"}, 256'(n), 256'(nr));
    check({tag, "_result"}, 256'(result), 256'(exp));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    check({tag, "_ready"}, 256'(ready), 256'(1));
  endtask

  initial begin
    logic [255:0] rk;
    logic [127:0] rb, exp;
    logic         ed;
    build_sbox();
    rst_n = 1'b0; encdec = 1'b1; init = 1'b0; next = 1'b0; keylen = 1'b0; key = '0; block = '0;
    repeat (2) tick();
    check("rst_ready", 256'(ready), 256'(1));
    check("rst_valid", 256'(result_valid), 256'(0));
    check("rst_result", 256'(result), 256'(0));
    rst_n = 1'b1;
    tick();

    do_init({KFIP, 128'hdeadbeefcafef00d0123456789abcdef}, 1'b0, "fips_init");
    run_block(PTF, 1'b1, CTF, 10, "fips_enc");
    do_init({K128, 128'h0}, 1'b0, "a128_init");
    run_block(PT, 1'b1, CT128, 10, "a128_enc");
`ifdef AES_CORE_DEC_EN
    run_block(CT128, 1'b0, PT, 10, "a128_dec");
`else
    run_block(PT, 1'b0, CT128, 10, "a128_encdec_ignored");
`endif
    do_init(K256, 1'b1, "a256_init");
    run_block(PT, 1'b1, CT256, 14, "a256_enc");
`ifdef AES_CORE_DEC_EN
    run_block(CT256, 1'b0, PT, 14, "a256_dec");
`endif

    // 100 random AES-256 blocks, back to back on one expanded key
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_init(rk, 1'b1, "rnd_init");
    for (int i = 0; i < 100; i++) begin
      rb = {$urandom, $urandom, $urandom, $urandom};
      ed = 1'($urandom_range(0, 1));
`ifdef AES_CORE_DEC_EN
      exp = aes_model(rk, 1'b1, rb, ed);
`else
      exp = aes_model(rk, 1'b1, rb, 1'b1);
`endif
      run_block(rb, ed, exp, 14, $sformatf("rnd%0d", i));
    end

    // next during expansion is dropped
    key = {KFIP, 128'h0}; keylen = 1'b0; init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    block = PTF; encdec = 1'b1; next = 1'b1;
    tick();
    next = 1'b0;
    wait_ready("busy_next");
    repeat (16) tick();
    check("busy_next_ignored", 256'(result_valid), 256'(0));

    // init mid-cipher aborts, result keeps the previous block
    run_block(PTF, 1'b1, CTF, 10, "pre_abort");
    block = PT; encdec = 1'b1; next = 1'b1;
    tick();
    next = 1'b0;
    repeat (3) tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    check("abort_valid", 256'(result_valid), 256'(0));
    check("abort_busy", 256'(ready), 256'(0));
    wait_ready("abort");
    repeat (16) tick();
    check("abort_no_result", 256'(result_valid), 256'(0));
    check("abort_result_held", 256'(result), 256'(CTF));

    // simultaneous init and next: expansion only
    run_block(PTF, 1'b1, CTF, 10, "pre_both");
    block = PT; init = 1'b1; next = 1'b1;
    tick();
    init = 1'b0; next = 1'b0;
    check("both_valid", 256'(result_valid), 256'(0));
    check("both_busy", 256'(ready), 256'(0));
    wait_ready("both");
    repeat (16) tick();
    check("both_no_cipher", 256'(result_valid), 256'(0));
    run_block(PT, 1'b1, aes_model({KFIP, 128'h0}, 1'b0, PT, 1'b1), 10, "post_both");

    // asynchronous reset in the middle of a cipher
    block = PT; encdec = 1'b1; next = 1'b1;
    tick();
    next = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 256'(ready), 256'(1));
    check("mid_rst_valid", 256'(result_valid), 256'(0));
    check("mid_rst_result", 256'(result), 256'(0));
    tick();
    rst_n = 1'b1;
    repeat (16) tick();
    check("post_rst_valid", 256'(result_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
